// File: rtl/if_pkg.sv
// Shared definitions for the fetch stage: redirect select encodings,
// the queued {pc, instr} entry type and the instruction size.
package if_pkg;

    localparam logic [1:0] SEL_NPC = 2'b00;
    localparam logic [1:0] SEL_TA  = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    localparam int INSTR_BYTES = 4;
    localparam int FE_XLEN     = 32;

    typedef struct packed {
        logic [FE_XLEN-1:0] pc;
        logic [FE_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// if_fifo: DEPTH-entry circular buffer of fetch entries with synchronous clear.
// Callers must only push when !full and only pop when !empty.
module if_fifo
    import if_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are AW bits wide, so DEPTH being a power of two makes them wrap for free.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/if_fetch_queue.sv
// IF stage with PC/nPC, redirect mux and a fetch queue draining to ID.
// Optional perf counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               IMEM_AW  = 9
) (
    input  logic                   clk,
    input  logic                   R,
    output logic [IMEM_AW-1:0]     imem_addr,
    input  logic [XLEN-1:0]        imem_rdata,
    input  logic                   redirect_valid,
    input  logic [1:0]             redirect_sel,
    input  logic [XLEN-1:0]        ta,
    input  logic [XLEN-1:0]        alu_out,
    input  logic                   flush,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [XLEN-1:0]        id_instr,
    output logic [XLEN-1:0]        id_pc,
    output logic [$clog2(DEPTH):0] q_count
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_squashed,
    output logic [31:0]            perf_full_cycles
`endif
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] target;
    logic            take_target;
    logic            clear;
    logic            fire;
    logic            pop;
    logic            full;
    logic            empty;
    entry_t          push_entry;
    entry_t          head;
    entry_t          last_head;

    // Any redirect_valid squashes the queue; only TA/ALU selects actually move the PC.
    assign take_target = redirect_valid && (redirect_sel == SEL_TA || redirect_sel == SEL_ALU);
    assign target      = (redirect_sel == SEL_ALU) ? alu_out : ta;
    assign clear       = redirect_valid || flush;
    assign fire        = !full && !clear;

    // ID handshake: an entry transfers on a cycle where id_valid && id_ready are both high.
    assign pop         = !empty && id_ready && !clear;

    assign push_entry  = '{pc: pc, instr: imem_rdata};
    assign imem_addr   = pc[IMEM_AW-1:0];

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            pc  <= RESET_PC;
            npc <= RESET_PC + STEP;
        end else if (take_target) begin
            pc  <= target;
            npc <= target + STEP;
        end else if (fire) begin
            pc  <= npc;
            npc <= npc + STEP;
        end
    end

    if_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (R),
        .clear (clear),
        .push  (fire),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (q_count)
    );

    // While empty the head outputs show the last entry presented, not stale storage.
    always_ff @(posedge clk or posedge R) begin
        if (R)           last_head <= '0;
        else if (!empty) last_head <= head;
    end

    assign id_valid = !empty;
    assign id_pc    = empty ? last_head.pc    : head.pc;
    assign id_instr = empty ? last_head.instr : head.instr;

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            perf_fetched     <= '0;
            perf_squashed    <= '0;
            perf_full_cycles <= '0;
        end else begin
            if (fire)  perf_fetched     <= perf_fetched + 32'd1;
            if (clear) perf_squashed    <= perf_squashed + 32'(q_count);
            if (full)  perf_full_cycles <= perf_full_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-level reference model plus directed scenarios.
// Perf counter checks are compiled when IF_PERF_CNT_EN is defined.
module tb_if_fetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [8:0]      imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect_valid = 1'b0;
    logic [1:0]      redirect_sel = 2'b00;
    logic [31:0]     ta = '0;
    logic [31:0]     alu_out = '0;
    logic            flush = 1'b0;
    logic            id_valid;
    logic            id_ready = 1'b1;
    logic [31:0]     id_instr;
    logic [31:0]     id_pc;
    logic [CW-1:0]   q_count;
`ifdef IF_PERF_CNT_EN
    logic [31:0]     perf_fetched;
    logic [31:0]     perf_squashed;
    logic [31:0]     perf_full_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0),
        .IMEM_AW  (9)
    ) dut (
        .clk            (clk),
        .R              (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_sel   (redirect_sel),
        .ta             (ta),
        .alu_out        (alu_out),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .q_count        (q_count)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched     (perf_fetched),
        .perf_squashed    (perf_squashed),
        .perf_full_cycles (perf_full_cycles)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [8:0] a);
        return {16'hC0DE, 7'd0, a};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of {pc, instr} plus the architectural pc/npc.
    logic [63:0] exp_q[$];
    logic [31:0] m_pc  = 32'h0;
    logic [31:0] m_npc = 32'h4;
    logic [31:0] m_fetched  = 0;
    logic [31:0] m_squashed = 0;
    logic [31:0] m_full     = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_pc = 32'h0;
            m_npc = 32'h4;
            m_fetched = 0;
            m_squashed = 0;
            m_full = 0;
        end else begin
            bit was_full;
            was_full = (exp_q.size() == DEPTH);
            if (was_full) m_full = m_full + 1;
            if (redirect_valid) begin
                m_squashed = m_squashed + exp_q.size();
                exp_q.delete();
                if (redirect_sel == 2'b01) begin
                    m_pc = ta; m_npc = ta + 4;
                end else if (redirect_sel == 2'b10) begin
                    m_pc = alu_out; m_npc = alu_out + 4;
                end
            end else if (flush) begin
                m_squashed = m_squashed + exp_q.size();
                exp_q.delete();
            end else begin
                if (exp_q.size() > 0 && id_ready) void'(exp_q.pop_front());
                if (!was_full) begin
                    exp_q.push_back({m_pc, mem_word(m_pc[8:0])});
                    m_pc = m_npc;
                    m_npc = m_npc + 4;
                    m_fetched = m_fetched + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("q_count", 32'(q_count), exp_q.size());
            check("id_valid", 32'(id_valid), 32'(exp_q.size() != 0));
            check("imem_addr", 32'(imem_addr), 32'(m_pc[8:0]));
            if (exp_q.size() != 0) begin
                check("id_pc", id_pc, exp_q[0][63:32]);
                check("id_instr", id_instr, exp_q[0][31:0]);
            end
`ifdef IF_PERF_CNT_EN
            check("perf_fetched", perf_fetched, m_fetched);
            check("perf_squashed", perf_squashed, m_squashed);
            check("perf_full_cycles", perf_full_cycles, m_full);
`endif
        end
    end

    task automatic do_reset();
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        // Reset values and free-running fetch with id_ready held high.
        repeat (2) @(negedge clk);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_q_count", 32'(q_count), 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("first_valid", 32'(id_valid), 32'd1);
        check("run_pc0", id_pc, 32'h0);
        @(negedge clk); check("run_pc4", id_pc, 32'h4);
        @(negedge clk); check("run_pc8", id_pc, 32'h8);
        @(negedge clk); check("run_pc12", id_pc, 32'hC);
        check("run_instr12", id_instr, 32'hC0DE_000C);

        // Stall ID: queue saturates at DEPTH, pc parks at 16, then drains in order.
        id_ready = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        check("stall_count", 32'(q_count), 32'd4);
        check("stall_pc", 32'(imem_addr), 32'h10);
        id_ready = 1'b1;
        check("drain_pc0", id_pc, 32'h0);
        @(negedge clk); check("drain_pc4", id_pc, 32'h4);
        @(negedge clk); check("drain_pc8", id_pc, 32'h8);
        @(negedge clk); check("drain_pc12", id_pc, 32'hC);

        // Redirect to TA with three entries queued.
        id_ready = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        check("pre_redir_count", 32'(q_count), 32'd3);
        redirect_valid = 1'b1; redirect_sel = 2'b01; ta = 32'h100;
        @(negedge clk);
        check("redir_count", 32'(q_count), 32'd0);
        redirect_valid = 1'b0; id_ready = 1'b1;
        @(negedge clk); check("redir_pc100", id_pc, 32'h100);
        @(negedge clk); check("redir_pc104", id_pc, 32'h104);
`ifdef IF_PERF_CNT_EN
        check("perf_squashed_3", perf_squashed, 32'd3);
`endif

        // ALU redirect wins over a simultaneous flush and pop.
        redirect_valid = 1'b1; redirect_sel = 2'b10; alu_out = 32'h40; flush = 1'b1;
        @(negedge clk);
        check("alu_count", 32'(q_count), 32'd0);
        redirect_valid = 1'b0; flush = 1'b0;
        @(negedge clk); check("alu_pc40", id_pc, 32'h40);

        // Flush alone holds pc; sel=00 redirect acts as a flush.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        redirect_valid = 1'b1; redirect_sel = 2'b00;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);

        // Async reset while full takes effect between clock edges.
        id_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("full_count", 32'(q_count), 32'd4);
        #2 rst = 1'b1;
        #1;
        check("async_valid", 32'(id_valid), 32'd0);
        check("async_count", 32'(q_count), 32'd0);
        check("async_pc", 32'(imem_addr), 32'd0);
        @(negedge clk); #1 rst = 1'b0;
        id_ready = 1'b1;

        // PC wrap through 2^32.
        @(negedge clk);
        redirect_valid = 1'b1; redirect_sel = 2'b01; ta = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk); check("wrap_f8", id_pc, 32'hFFFF_FFF8);
        @(negedge clk); check("wrap_fc", id_pc, 32'hFFFF_FFFC);
        @(negedge clk); check("wrap_0", id_pc, 32'h0);

        // Mixed traffic checked by the model.
        for (int i = 0; i < 200; i++) begin
            int r;
            @(negedge clk);
            r = $urandom_range(0, 15);
            id_ready       = 1'($urandom_range(0, 1));
            flush          = (r == 0);
            redirect_valid = (r == 1);
            redirect_sel   = 2'($urandom_range(0, 3));
            ta             = $urandom;
            alu_out        = $urandom;
        end
        @(negedge clk);
        redirect_valid = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised successor of the current IF stage. It holds the PC/nPC pair and a redirect mux (nPC / TA / ALU target), fetches one instruction word per cycle from a combinational instruction memory, and buffers {pc, instr} pairs in a DEPTH-entry fetch queue. The queue drains to ID through a valid/ready handshake, replacing the single IF/ID register so IF keeps fetching while ID stalls. A redirect or flush squashes the queue contents.

Parameters:
XLEN, 32, width of PC, nPC, targets and instruction word
DEPTH, 4, fetch queue entries; power of two, range 2..16
RESET_PC, 0, PC value after reset; nPC resets to RESET_PC+4
IMEM_AW, 9, byte-address width driven to instruction memory

Ports:
clk  in  1  clock, all state updates on posedge
R  in  1  reset, asynchronous, active-high
imem_addr  out  IMEM_AW  byte address = pc[IMEM_AW-1:0]
imem_rdata  in  XLEN  instruction word, combinational from imem_addr
redirect_valid  in  1  load new fetch target this cycle
redirect_sel  in  2  00 nPC (sequential), 01 TA, 10 ALU, 11 reserved
ta  in  XLEN  branch/call target address
alu_out  in  XLEN  jmpl/register-indirect target
flush  in  1  squash queue without changing PC/nPC
id_valid  out  1  queue head valid
id_ready  in  1  ID accepts head this cycle
id_instr  out  XLEN  head instruction
id_pc  out  XLEN  head PC
q_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, R=1): pc=RESET_PC, npc=RESET_PC+4, queue empty (wr_ptr=rd_ptr=0, count=0), id_valid=0, id_instr=0, id_pc=0, perf counters 0. Reset takes effect immediately, including mid-fetch or mid-drain.
- Fetch: fire = !full && !redirect_valid && !flush. On fire, push {pc, imem_rdata}, then pc<=npc and npc<=npc+4 (mod 2^XLEN, wraps silently).
- Redirect: when redirect_valid and redirect_sel=01 or 10, target=ta or alu_out. Clear the queue, set pc<=target and npc<=target+4. No push occurs that cycle, so the first redirected instruction enters the queue one cycle later.
- redirect_sel=00 with redirect_valid: no redirect; treat the cycle as a flush only. redirect_sel=11: same as 00.
- flush alone: clear the queue and hold pc/npc; fetch resumes next cycle.
- Priority: R > redirect_valid > flush > push/pop.
- Pop: when id_valid && id_ready, rd_ptr advances. Push and pop in the same cycle keep the count unchanged.
- A full queue with a simultaneous pop does not fetch that cycle; full is evaluated on the registered count. Fetch restarts the cycle after the count drops.
- Empty: id_valid=0, and id_instr/id_pc hold their last values. ID must ignore them.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- Head outputs are read combinationally from storage. Fetch-to-ID latency is 1 cycle when the queue is empty.
- Word alignment is not checked. imem_addr uses pc[1:0] as-is.

Optional Feature:
IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetched [31:0] (count of pushes), perf_squashed [31:0] (count of valid entries discarded by a redirect or flush) and perf_full_cycles [31:0] (cycles spent full). All wrap at 2^32 and are cleared by R.
- Undefined: these ports and counters are absent; the rest of the block is identical.

Decomposition:
- Package if_pkg: redirect_sel encodings (SEL_NPC=2'b00, SEL_TA=2'b01, SEL_ALU=2'b10), the fetch_entry_t struct {pc, instr}, and the INSTR_BYTES=4 constant.
- Sub-module if_fifo: parametrised DEPTH x fetch_entry_t circular buffer with push, pop, clear, full, empty and count. The top level holds the PC/nPC logic, the redirect mux and the perf counters.

Test Plan:
- Reset then free-run with id_ready=1, RESET_PC=0 -> id_pc sequence 0,4,8,12 on consecutive cycles; the first id_valid appears 1 cycle after R falls.
- id_ready=0 for 10 cycles, DEPTH=4 -> q_count saturates at 4, pc holds at 16, no entry is overwritten. Release id_ready -> entries 0,4,8,12 drain in order.
- With the queue holding 3 entries, pulse redirect_valid, redirect_sel=01, ta=0x100 -> q_count=0 next cycle, then id_pc=0x100, 0x104. With IF_PERF_CNT_EN, perf_squashed=3.
- Redirect with redirect_sel=10, alu_out=0x40, in the same cycle as id_ready=1 and flush=1 -> redirect wins: queue cleared, next id_pc=0x40.
- Assert R asynchronously mid-cycle while the queue is full -> id_valid=0, q_count=0 and pc=RESET_PC immediately, without waiting for a clk edge.
- Preload pc=0xFFFFFFF8 via a TA redirect -> fetched pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x0 (npc wraps).
